// File: rtl/i8254_pkg.sv
// Shared encodings for the 8254 access sequencer: RW formats, control-word fields, status layout.
// The READBACK_EN build option uses the read-back and status constants defined here.
package i8254_pkg;

    typedef enum logic [1:0] {
        RW_LATCH   = 2'b00,
        RW_LSB     = 2'b01,
        RW_MSB     = 2'b10,
        RW_LSB_MSB = 2'b11
    } rw_t;

    localparam int NUM_COUNTERS = 3;
    localparam int MODE_W       = 3;

    localparam logic [1:0] SC_READBACK = 2'b11;

    // Control-word field positions.
    localparam int CW_SC_LSB  = 6;
    localparam int CW_RW_LSB  = 4;
    localparam int CW_M_LSB   = 1;
    localparam int CW_BCD_BIT = 0;

    // Read-back command bits: active-low count/status selects, counter select mask.
    localparam int RB_COUNT_N_BIT  = 5;
    localparam int RB_STATUS_N_BIT = 4;
    localparam int RB_SEL_LSB      = 1;

    // Status byte layout.
    localparam int ST_OUT_BIT  = 7;
    localparam int ST_NULL_BIT = 6;
    localparam int ST_RW_LSB   = 4;
    localparam int ST_M_LSB    = 1;
    localparam int ST_BCD_BIT  = 0;

    // Modes 6 and 7 are aliases of modes 2 and 3.
    function automatic logic [MODE_W-1:0] fold_mode(input logic [MODE_W-1:0] m);
        return (m[2] && m[1]) ? {1'b0, m[1:0]} : m;
    endfunction

    function automatic logic [7:0] status_byte(input logic out_pin, input logic null_cnt,
                                               input logic [1:0] rw, input logic [MODE_W-1:0] m,
                                               input logic bcd);
        logic [7:0] sb;
        sb                       = '0;
        sb[ST_OUT_BIT]           = out_pin;
        sb[ST_NULL_BIT]          = null_cnt;
        sb[ST_RW_LSB +: 2]       = rw;
        sb[ST_M_LSB +: MODE_W]   = m;
        sb[ST_BCD_BIT]           = bcd;
        return sb;
    endfunction

endpackage

// File: rtl/i8254_access_channel.sv
// One counter's access state: RW format, mode, byte pointers, count latch and Null_Count.
// With READBACK_EN defined, a status latch is also built and served ahead of count bytes.
module i8254_access_channel
    import i8254_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_wr,
    input  logic [1:0]        ctrl_rw,
    input  logic [MODE_W-1:0] ctrl_mode,
    input  logic              ctrl_bcd,
    input  logic              cnt_latch,
    input  logic              sts_latch,
    input  logic              cnt_out,
    input  logic              wr_fire,
    input  logic              rd_fire,
    input  logic [7:0]        data_in,
    input  logic [15:0]       count_value,
    output logic [7:0]        rd_data,
    output logic [15:0]       count_load,
    output logic              load_strobe,
    output logic [MODE_W-1:0] mode,
    output logic              bcd,
    output logic              null_count
);

    rw_t         rw;
    logic        wr_msb;
    logic        rd_msb;
    logic [7:0]  lsb_hold;
    logic [15:0] latch_q;
    logic        latch_valid;
    logic        sts_first;
    logic [15:0] rd_src;
    logic [7:0]  cnt_byte;
    logic        last_byte;

    assign rd_src    = latch_valid ? latch_q : count_value;
    assign last_byte = (rw != RW_LSB_MSB) || rd_msb;

    always_comb begin
        cnt_byte = rd_src[7:0];
        case (rw)
            RW_MSB:     cnt_byte = rd_src[15:8];
            RW_LSB_MSB: cnt_byte = rd_msb ? rd_src[15:8] : rd_src[7:0];
            default:    cnt_byte = rd_src[7:0];
        endcase
    end

`ifdef READBACK_EN
    logic [7:0] sts_q;
    logic       sts_valid;

    assign sts_first = sts_valid;
    assign rd_data   = sts_valid ? sts_q : cnt_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sts_q     <= '0;
            sts_valid <= 1'b0;
        end else if (ctrl_wr) begin
            sts_valid <= 1'b0;
        end else if (sts_latch && !sts_valid) begin
            sts_q     <= status_byte(cnt_out, null_count, rw, mode, bcd);
            sts_valid <= 1'b1;
        end else if (rd_fire && sts_valid) begin
            sts_valid <= 1'b0;
        end
    end
`else
    logic unused_readback;

    assign unused_readback = sts_latch ^ cnt_out;
    assign sts_first       = 1'b0;
    assign rd_data         = cnt_byte;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw          <= RW_LSB;
            mode        <= '0;
            bcd         <= 1'b0;
            wr_msb      <= 1'b0;
            rd_msb      <= 1'b0;
            lsb_hold    <= '0;
            latch_q     <= '0;
            latch_valid <= 1'b0;
            null_count  <= 1'b1;
            count_load  <= '0;
            load_strobe <= 1'b0;
        end else begin
            load_strobe <= 1'b0;
            if (ctrl_wr) begin
                // A new control word abandons any half-finished byte sequence.
                rw          <= rw_t'(ctrl_rw);
                mode        <= fold_mode(ctrl_mode);
                bcd         <= ctrl_bcd;
                wr_msb      <= (ctrl_rw == RW_MSB);
                rd_msb      <= (ctrl_rw == RW_MSB);
                latch_valid <= 1'b0;
                null_count  <= 1'b1;
            end else begin
                if (cnt_latch && !latch_valid) begin
                    latch_q     <= count_value;
                    latch_valid <= 1'b1;
                end
                if (wr_fire) begin
                    case (rw)
                        RW_MSB: begin
                            count_load  <= {data_in, 8'h00};
                            load_strobe <= 1'b1;
                            null_count  <= 1'b0;
                        end
                        RW_LSB_MSB: begin
                            if (wr_msb) begin
                                count_load  <= {data_in, lsb_hold};
                                load_strobe <= 1'b1;
                                null_count  <= 1'b0;
                                wr_msb      <= 1'b0;
                            end else begin
                                lsb_hold <= data_in;
                                wr_msb   <= 1'b1;
                            end
                        end
                        default: begin
                            count_load  <= {8'h00, data_in};
                            load_strobe <= 1'b1;
                            null_count  <= 1'b0;
                        end
                    endcase
                end
                if (rd_fire && !sts_first) begin
                    if (last_byte) latch_valid <= 1'b0;
                    if (rw == RW_LSB_MSB) rd_msb <= ~rd_msb;
                end
            end
        end
    end

endmodule

// File: rtl/i8254_access_sequencer.sv
// Edge-detects the one-hot bus enables, decodes control words and muxes read data for three counters.
// Define READBACK_EN to honour SC=11 read-back commands; otherwise they are ignored.
module i8254_access_sequencer
    import i8254_pkg::*;
#(
    parameter int COUNT_W = 16,
    parameter int DATA_W  = 8
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic [3:0]            Write_Enable,
    input  logic [3:0]            Read_Enable,
    input  logic [DATA_W-1:0]     Data_In,
    input  logic [3*COUNT_W-1:0]  Count_Value,
    input  logic [2:0]            Counter_Out,
    output logic [DATA_W-1:0]     Data_Out,
    output logic                  Data_Out_Valid,
    output logic [3*COUNT_W-1:0]  Count_Load,
    output logic [2:0]            Load_Strobe,
    output logic [3*MODE_W-1:0]   Mode,
    output logic [2:0]            Bcd,
    output logic [2:0]            Null_Count
);

    // Data_Out_Valid is a one-cycle strobe with no back-pressure; Data_Out holds between strobes.
    logic [3:0]        we_q;
    logic [2:0]        re_q;
    logic [3:0]        we_fire;
    logic [2:0]        rd_fire;
    logic [1:0]        cw_sc;
    logic [1:0]        cw_rw;
    logic [MODE_W-1:0] cw_m;
    logic              cw_bcd;
    logic [2:0]        ctrl_wr;
    logic [2:0]        cnt_latch;
    logic [2:0]        sts_latch;
    logic [7:0]        rd_data [NUM_COUNTERS];
    logic [7:0]        rd_sel;
    logic              unused_ctrl_read;

    // Reads of the control register address produce nothing.
    assign unused_ctrl_read = Read_Enable[3];

    assign we_fire = Write_Enable & ~we_q;
    assign rd_fire = (Write_Enable == 4'b0000) ? (Read_Enable[2:0] & ~re_q) : 3'b000;

    assign cw_sc  = Data_In[CW_SC_LSB +: 2];
    assign cw_rw  = Data_In[CW_RW_LSB +: 2];
    assign cw_m   = Data_In[CW_M_LSB +: MODE_W];
    assign cw_bcd = Data_In[CW_BCD_BIT];

    always_comb begin
        ctrl_wr   = '0;
        cnt_latch = '0;
        sts_latch = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (we_fire[3] && (cw_sc == 2'(i))) begin
                if (cw_rw == RW_LATCH) cnt_latch[i] = 1'b1;
                else                   ctrl_wr[i]   = 1'b1;
            end
`ifdef READBACK_EN
            if (we_fire[3] && (cw_sc == SC_READBACK) && Data_In[RB_SEL_LSB + i]) begin
                cnt_latch[i] = ~Data_In[RB_COUNT_N_BIT];
                sts_latch[i] = ~Data_In[RB_STATUS_N_BIT];
            end
`endif
        end
    end

    always_comb begin
        rd_sel = rd_data[0];
        if (rd_fire[1]) rd_sel = rd_data[1];
        if (rd_fire[2]) rd_sel = rd_data[2];
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            we_q           <= '0;
            re_q           <= '0;
            Data_Out       <= '0;
            Data_Out_Valid <= 1'b0;
        end else begin
            we_q           <= Write_Enable;
            re_q           <= Read_Enable[2:0];
            Data_Out_Valid <= |rd_fire;
            if (|rd_fire) Data_Out <= rd_sel;
        end
    end

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_ch
        i8254_access_channel u_ch (
            .clk         (Clock),
            .rst_n       (Reset_n),
            .ctrl_wr     (ctrl_wr[i]),
            .ctrl_rw     (cw_rw),
            .ctrl_mode   (cw_m),
            .ctrl_bcd    (cw_bcd),
            .cnt_latch   (cnt_latch[i]),
            .sts_latch   (sts_latch[i]),
            .cnt_out     (Counter_Out[i]),
            .wr_fire     (we_fire[i]),
            .rd_fire     (rd_fire[i]),
            .data_in     (Data_In),
            .count_value (Count_Value[COUNT_W*i +: COUNT_W]),
            .rd_data     (rd_data[i]),
            .count_load  (Count_Load[COUNT_W*i +: COUNT_W]),
            .load_strobe (Load_Strobe[i]),
            .mode        (Mode[MODE_W*i +: MODE_W]),
            .bcd         (Bcd[i]),
            .null_count  (Null_Count[i])
        );
    end

endmodule
